f_spsram_arb: RTL and testbench
===============================

# f_spsram_arb

Two-port arbiter and access sequencer for the single-port 2048x128 byte-writable SRAM macro. It shares the macro between two requesters, port 0 and port 1, using round-robin grants. It converts active-high request, write and byte-enable signals into the macro's active-low CEN/WEN controls. It returns read data one cycle after the grant and holds it under back-pressure. It sits directly between the macro and its clients (for example a fetch path and a bus slave).

## Interface
- ADDR_WIDTH, 11, word address width (2048 entries)
- DATA_WIDTH, 128, data width; BE_WIDTH = DATA_WIDTH/8
- CLK  in  1  clock; the macro uses the same clock
- RST  in  1  synchronous reset, active-high
- pN_req  in  1  port N (N=0,1) request valid
- pN_wr  in  1  1 = write, 0 = read
- pN_addr  in  ADDR_WIDTH  word address
- pN_wdata  in  DATA_WIDTH  write data
- pN_be  in  BE_WIDTH  byte enables, active-high
- pN_gnt  out  1  request accepted this cycle (combinational)
- pN_rvalid  out  1  read data valid
- pN_rdata  out  DATA_WIDTH  read data
- pN_rready  in  1  read data consumed
- A  out  ADDR_WIDTH  macro address
- CEN  out  1  macro chip enable, active-low
- D  out  DATA_WIDTH  macro write data
- WEN  out  BE_WIDTH  macro byte write enables, active-low
- Q  in  DATA_WIDTH  macro read data

## Operation
- A port is eligible when pN_req=1 and it is not blocked. A port is blocked when pN_rvalid=1 and pN_rready=0.
- Only one eligible port: that port is granted.
- Both ports eligible: the port not recorded in the last_gnt register wins. last_gnt updates on every grant.
- The grant drives the macro in the same cycle:
  - CEN=0.
  - A = granted address.
  - D = granted wdata.
  - Write: WEN = ~be. Read: WEN = all ones.
- No grant: CEN=1, WEN = all ones, A and D hold their previous values (registered mux select, no toggling).
- Write with be=0: CEN=0, no byte is written, no response is generated.
- Writes produce no response.
- Read granted at cycle t: rd_pend_N is set for cycle t+1. At t+1, pN_rvalid=1 and pN_rdata=Q.
- If pN_rready=0 at t+1, Q is captured into hold_N. pN_rvalid stays 1 and pN_rdata comes from hold_N until a cycle with rready=1.
- Per-port state: IDLE → PEND (cycle after a read grant) → HOLD (PEND with rready=0).
  - PEND or HOLD exits to IDLE on rready=1.
  - PEND or HOLD exits to PEND instead if a new read is granted in the same cycle (pipelined back-to-back reads).
- A blocked port is never granted. The other port may use the macro freely, because hold_N already holds the data.

## Timing
- Grant latency 0 (combinational from req). Read data latency 1 cycle.
- Throughput: one access per cycle across both ports. A single port can issue back-to-back reads while it keeps rready=1.
- Simultaneous requests: each gets one grant in alternating cycles.
- Reset values:
  - pN_gnt=0, pN_rvalid=0, pN_rdata=0.
  - CEN=1, WEN = all ones, A=0, D=0.
  - last_gnt=1, so port 0 wins the first contention.
- Reset mid-operation: pending and held responses are discarded, and rvalid=0 on the next cycle. A write granted in the same cycle as RST=1 is suppressed (CEN=1).
- Same-address read after a write in the previous cycle returns the new data; the macro is write-first by sequence.

## Configuration
- F_SPSRAM_ARB_FIXED_PRI_EN
  - Defined: fixed priority, port 0 always wins contention, and last_gnt is not implemented.
  - Undefined (default): round-robin as above.
  - Blocking and response behaviour are identical in both modes.

## Test plan
- Single write then read: p0 writes addr 0x005, data 0x00112233_44556677_8899AABB_CCDDEEFF, be=0xFFFF; p0 reads 0x005 → CEN=0 both cycles, WEN=0x0000 then 0xFFFF, p0_rvalid=1 one cycle after the read grant with matching data.
- Byte mask: write 0xFF…FF, be=0xFFFF to 0x7FF, then data 0, be=0x0001 → WEN=0xFFFE; readback = 0xFF…FF00.
- Contention: both ports request reads every cycle for 6 cycles after reset → grants p0,p1,p0,p1,p0,p1 (fixed-priority build: p0 ×6, p1 never).
- Back-pressure: p1 reads 0x010, p1_rready=0 for 3 cycles while p0 writes 0x010 → p1_rdata keeps the old value, p1_gnt=0 for new p1 requests, release on rready=1.
- Back-to-back reads: p0 reads 0x001, 0x002, 0x003 on consecutive cycles with rready=1 → rvalid high 3 consecutive cycles, data in order.
- Reset mid-hold: assert RST while p0 is in HOLD → p0_rvalid=0, CEN=1 next cycle, and p0 wins the first contention after release.

Source files
------------

// File: rtl/f_spsram_arb.sv
// f_spsram_arb
// Two-port arbiter and access sequencer for the single-port 2048x128
// byte-writable SRAM macro. Port 0 and port 1 share the macro under
// round-robin grants. Active-high request/write/byte-enable controls are
// turned into the macro's active-low CEN/WEN. Read data is returned one
// cycle after the grant and is held in a per-port register under
// back-pressure.
//
// Build option:
//   F_SPSRAM_ARB_FIXED_PRI_EN  defined   -> port 0 always wins contention,
//                                           no last_gnt register
//                              undefined -> round-robin (default)
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   pN_req/wr/addr/wdata/be  port N request (N = 0,1)
//   pN_gnt                   request accepted this cycle (combinational)
//   pN_rvalid/rdata/rready   port N read response handshake
//   A, CEN, D, WEN, Q        SRAM macro interface (CEN/WEN active-low)
module f_spsram_arb #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 128,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  p0_req,
    input  logic                  p0_wr,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic [BE_WIDTH-1:0]   p0_be,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p0_rready,
    input  logic                  p1_req,
    input  logic                  p1_wr,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    input  logic [BE_WIDTH-1:0]   p1_be,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    input  logic                  p1_rready,
    output logic [ADDR_WIDTH-1:0] A,
    output logic                  CEN,
    output logic [DATA_WIDTH-1:0] D,
    output logic [BE_WIDTH-1:0]   WEN,
    input  logic [DATA_WIDTH-1:0] Q
);

    // Per-port response state
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;  // macro Q carries this port's data
    localparam logic [1:0] ST_HOLD = 2'd2;  // data parked in hold_N

    logic [1:0]            st0, st1;
    logic [DATA_WIDTH-1:0] hold0, hold1;

    logic                  elig0, elig1;
    logic                  gnt0, gnt1, any_gnt;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr, a_q;
    logic [DATA_WIDTH-1:0] sel_wdata, d_q;
    logic [BE_WIDTH-1:0]   sel_be;

    // A port whose response is still unconsumed may not issue: this keeps
    // the single hold register per port sufficient. Reset suppresses any
    // grant in the same cycle so no access reaches the macro.
    assign elig0 = p0_req & ~(p0_rvalid & ~p0_rready) & ~RST;
    assign elig1 = p1_req & ~(p1_rvalid & ~p1_rready) & ~RST;

`ifdef F_SPSRAM_ARB_FIXED_PRI_EN
    assign gnt0 = elig0;
    assign gnt1 = elig1 & ~elig0;
`else
    // last_gnt: 0 = port 0 granted last, 1 = port 1 granted last
    logic last_gnt;

    assign gnt0 = elig0 & (~elig1 | last_gnt);
    assign gnt1 = elig1 & (~elig0 | ~last_gnt);

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_gnt <= 1'b1;
        end else if (gnt0) begin
            last_gnt <= 1'b0;
        end else if (gnt1) begin
            last_gnt <= 1'b1;
        end
    end
`endif

    assign p0_gnt  = gnt0;
    assign p1_gnt  = gnt1;
    assign any_gnt = gnt0 | gnt1;

    always_comb begin
        sel_wr    = p0_wr;
        sel_addr  = p0_addr;
        sel_wdata = p0_wdata;
        sel_be    = p0_be;
        if (gnt1) begin
            sel_wr    = p1_wr;
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
            sel_be    = p1_be;
        end
    end

    // Macro drive. A and D keep the last granted values when idle so the
    // macro pins do not toggle between accesses.
    assign CEN = ~any_gnt;
    assign WEN = (any_gnt & sel_wr) ? ~sel_be : '1;
    assign A   = any_gnt ? sel_addr  : a_q;
    assign D   = any_gnt ? sel_wdata : d_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q <= '0;
            d_q <= '0;
        end else if (any_gnt) begin
            a_q <= sel_addr;
            d_q <= sel_wdata;
        end
    end

    // A new read granted while the previous response is being consumed
    // goes straight back to PEND (pipelined back-to-back reads).
    function automatic logic [1:0] next_st(input logic [1:0] st,
                                           input logic       rready,
                                           input logic       rd_gnt);
        logic [1:0] nx;
        nx = ST_IDLE;
        case (st)
            ST_IDLE: nx = rd_gnt ? ST_PEND : ST_IDLE;
            ST_PEND: nx = !rready ? ST_HOLD : (rd_gnt ? ST_PEND : ST_IDLE);
            ST_HOLD: nx = !rready ? ST_HOLD : (rd_gnt ? ST_PEND : ST_IDLE);
            default: nx = ST_IDLE;
        endcase
        return nx;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            st0   <= ST_IDLE;
            st1   <= ST_IDLE;
            hold0 <= '0;
            hold1 <= '0;
        end else begin
            st0 <= next_st(st0, p0_rready, gnt0 & ~p0_wr);
            st1 <= next_st(st1, p1_rready, gnt1 & ~p1_wr);
            if (st0 == ST_PEND && !p0_rready) begin
                hold0 <= Q;
            end
            if (st1 == ST_PEND && !p1_rready) begin
                hold1 <= Q;
            end
        end
    end

    assign p0_rvalid = (st0 != ST_IDLE);
    assign p1_rvalid = (st1 != ST_IDLE);

    assign p0_rdata = (st0 == ST_PEND) ? Q : ((st0 == ST_HOLD) ? hold0 : '0);
    assign p1_rdata = (st1 == ST_PEND) ? Q : ((st1 == ST_HOLD) ? hold1 : '0);

endmodule

// File: tb/tb_f_spsram_arb.sv
// tb_f_spsram_arb
// Directed test of f_spsram_arb against a behavioural model of the
// 2048x128 byte-writable SRAM macro (Q updates only on reads; a write is
// visible to a read in the following cycle). Macro contents are preloaded
// with word i = {4{16'hA5A5, i[15:0]}}.
module tb_f_spsram_arb;

    localparam int AW = 11;
    localparam int DW = 128;
    localparam int BW = 16;
`ifdef F_SPSRAM_ARB_FIXED_PRI_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic          p0_req, p0_wr, p0_rready, p1_req, p1_wr, p1_rready;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic [BW-1:0] p0_be, p1_be;
    logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] A;
    logic          CEN;
    logic [DW-1:0] D;
    logic [BW-1:0] WEN;
    logic [DW-1:0] Q = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    f_spsram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST),
        .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_be(p0_be), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
        .p0_rdata(p0_rdata), .p0_rready(p0_rready),
        .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_be(p1_be), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
        .p1_rdata(p1_rdata), .p1_rready(p1_rready),
        .A(A), .CEN(CEN), .D(D), .WEN(WEN), .Q(Q)
    );

    // SRAM macro model
    logic [DW-1:0] mem [2048];
    logic          preloaded = 1'b0;

    always @(posedge CLK) begin
        if (!preloaded) begin
            for (int i = 0; i < 2048; i++) mem[i] <= {4{16'hA5A5, 16'(i)}};
            preloaded <= 1'b1;
        end else if (!CEN) begin
            if (&WEN) begin
                Q <= mem[A];
            end else begin
                for (int b = 0; b < BW; b++)
                    if (!WEN[b]) mem[A][b*8 +: 8] <= D[b*8 +: 8];
            end
        end
    end

    task automatic check_vec(input string tag, input logic [DW-1:0] got,
                             input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drv0(input logic req, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [BW-1:0] be);
        p0_req = req; p0_wr = wr; p0_addr = addr; p0_wdata = wd; p0_be = be;
    endtask

    task automatic drv1(input logic req, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [BW-1:0] be);
        p1_req = req; p1_wr = wr; p1_addr = addr; p1_wdata = wd; p1_be = be;
    endtask

    task automatic idle();
        drv0(1'b0, 1'b0, '0, '0, '0);
        drv1(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic samp();
        @(negedge CLK);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    localparam logic [DW-1:0] DW1  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [DW-1:0] P1   = 128'hA5A50001_A5A50001_A5A50001_A5A50001;
    localparam logic [DW-1:0] P2   = 128'hA5A50002_A5A50002_A5A50002_A5A50002;
    localparam logic [DW-1:0] P3   = 128'hA5A50003_A5A50003_A5A50003_A5A50003;
    localparam logic [DW-1:0] P4   = 128'hA5A50004_A5A50004_A5A50004_A5A50004;
    localparam logic [DW-1:0] P10  = 128'hA5A50010_A5A50010_A5A50010_A5A50010;
    localparam logic [DW-1:0] NEWD = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

    initial begin
        RST = 1'b1;
        p0_rready = 1'b1;
        p1_rready = 1'b1;
        idle();
        step();

        // Reset state; a write requested during reset must not reach the macro
        drv0(1'b1, 1'b1, 11'h123, DW1, 16'hFFFF);
        samp();
        check_vec("rst_cen", CEN, 1);
        check_vec("rst_gnt0", p0_gnt, 0);
        check_vec("rst_gnt1", p1_gnt, 0);
        check_vec("rst_wen", WEN, 16'hFFFF);
        check_vec("rst_a", A, 0);
        check_vec("rst_d", D, 0);
        check_vec("rst_rvalid0", p0_rvalid, 0);
        check_vec("rst_rdata0", p0_rdata, 0);
        step();
        RST = 1'b0;

        // Single write then read
        drv0(1'b1, 1'b1, 11'h005, DW1, 16'hFFFF);
        samp();
        check_vec("wr_gnt", p0_gnt, 1);
        check_vec("wr_cen", CEN, 0);
        check_vec("wr_wen", WEN, 16'h0000);
        check_vec("wr_a", A, 11'h005);
        check_vec("wr_d", D, DW1);
        step();
        drv0(1'b1, 1'b0, 11'h005, '0, '0);
        samp();
        check_vec("rd_cen", CEN, 0);
        check_vec("rd_wen", WEN, 16'hFFFF);
        check_vec("wr_no_rvalid", p0_rvalid, 0);
        step();
        idle();
        samp();
        check_vec("rd_rvalid", p0_rvalid, 1);
        check_vec("rd_rdata", p0_rdata, DW1);
        check_vec("idle_cen", CEN, 1);
        check_vec("idle_a_hold", A, 11'h005);
        step();
        samp();
        check_vec("rd_rvalid_drop", p0_rvalid, 0);

        // Byte mask
        drv0(1'b1, 1'b1, 11'h7FF, '1, 16'hFFFF);
        step();
        drv0(1'b1, 1'b1, 11'h7FF, '0, 16'h0001);
        samp();
        check_vec("bm_wen", WEN, 16'hFFFE);
        step();
        drv0(1'b1, 1'b0, 11'h7FF, '0, '0);
        step();
        // be=0 write: access happens but no response follows
        drv0(1'b1, 1'b1, 11'h7FF, '0, 16'h0000);
        samp();
        check_vec("bm_rdata", p0_rdata, {{120{1'b1}}, 8'h00});
        check_vec("be0_cen", CEN, 0);
        check_vec("be0_wen", WEN, 16'hFFFF);
        step();
        idle();
        samp();
        check_vec("be0_no_rvalid", p0_rvalid, 0);
        step();

        // Contention right after reset
        RST = 1'b1;
        step();
        RST = 1'b0;
        drv0(1'b1, 1'b0, 11'h001, '0, '0);
        drv1(1'b1, 1'b0, 11'h002, '0, '0);
        for (int k = 0; k < 6; k++) begin
            samp();
            check_vec($sformatf("cont_gnt0_%0d", k), p0_gnt, FIXED ? 1'b1 : (k % 2 == 0));
            check_vec($sformatf("cont_gnt1_%0d", k), p1_gnt, FIXED ? 1'b0 : (k % 2 == 1));
            step();
        end
        idle();
        step();

        // Back-pressure on port 1 while port 0 uses the macro
        p1_rready = 1'b0;
        drv1(1'b1, 1'b0, 11'h010, '0, '0);
        samp();
        check_vec("bp_gnt1", p1_gnt, 1);
        step();
        drv0(1'b1, 1'b1, 11'h010, NEWD, 16'hFFFF);
        drv1(1'b1, 1'b0, 11'h011, '0, '0);
        samp();
        check_vec("bp_rvalid1_a", p1_rvalid, 1);
        check_vec("bp_rdata1_a", p1_rdata, P10);
        check_vec("bp_blk1_a", p1_gnt, 0);
        check_vec("bp_gnt0_wr", p0_gnt, 1);
        step();
        drv0(1'b0, 1'b0, '0, '0, '0);
        samp();
        check_vec("bp_blk1_b", p1_gnt, 0);
        check_vec("bp_cen_b", CEN, 1);
        check_vec("bp_rdata1_b", p1_rdata, P10);
        step();
        drv0(1'b1, 1'b0, 11'h010, '0, '0);
        samp();
        check_vec("bp_gnt0_rd", p0_gnt, 1);
        check_vec("bp_blk1_c", p1_gnt, 0);
        step();
        drv0(1'b0, 1'b0, '0, '0, '0);
        p1_rready = 1'b1;
        drv1(1'b1, 1'b0, 11'h010, '0, '0);
        samp();
        check_vec("bp_rdata1_rel", p1_rdata, P10);
        check_vec("bp_rvalid1_rel", p1_rvalid, 1);
        check_vec("bp_rdata0_new", p0_rdata, NEWD);
        check_vec("bp_gnt1_rel", p1_gnt, 1);
        step();
        idle();
        samp();
        check_vec("bp_rdata1_new", p1_rdata, NEWD);
        step();
        samp();
        check_vec("bp_rvalid1_drop", p1_rvalid, 0);

        // Back-to-back reads on port 0
        drv0(1'b1, 1'b0, 11'h001, '0, '0);
        step();
        drv0(1'b1, 1'b0, 11'h002, '0, '0);
        samp();
        check_vec("b2b_gnt_2", p0_gnt, 1);
        check_vec("b2b_rdata_1", p0_rdata, P1);
        step();
        drv0(1'b1, 1'b0, 11'h003, '0, '0);
        samp();
        check_vec("b2b_rvalid_2", p0_rvalid, 1);
        check_vec("b2b_rdata_2", p0_rdata, P2);
        step();
        idle();
        samp();
        check_vec("b2b_rvalid_3", p0_rvalid, 1);
        check_vec("b2b_rdata_3", p0_rdata, P3);
        step();
        samp();
        check_vec("b2b_rvalid_end", p0_rvalid, 0);

        // Reset while port 0 holds a response
        p0_rready = 1'b0;
        drv0(1'b1, 1'b0, 11'h004, '0, '0);
        step();
        idle();
        step();
        drv0(1'b1, 1'b0, 11'h001, '0, '0);
        drv1(1'b1, 1'b0, 11'h002, '0, '0);
        samp();
        check_vec("mh_hold_rdata", p0_rdata, P4);
        RST = 1'b1;
        #1;
        check_vec("mh_rst_cen", CEN, 1);
        check_vec("mh_rst_gnt1", p1_gnt, 0);
        step();
        RST = 1'b0;
        p0_rready = 1'b1;
        idle();
        samp();
        check_vec("mh_rvalid0", p0_rvalid, 0);
        check_vec("mh_cen", CEN, 1);
        check_vec("mh_a", A, 0);
        step();
        drv0(1'b1, 1'b0, 11'h001, '0, '0);
        drv1(1'b1, 1'b0, 11'h002, '0, '0);
        samp();
        check_vec("mh_first_gnt0", p0_gnt, 1);
        check_vec("mh_first_gnt1", p1_gnt, 0);
        step();
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
